// File: rtl/microwave_pkg.sv
// Shared state encoding and key polarity for the microwave controller.
package microwave_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARMED  = 3'd1,
        ST_COOK   = 3'd2,
        ST_PAUSED = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    // Keypad lines idle high; a press is a transition away from this level.
    localparam logic KEY_RELEASED = 1'b1;

endpackage

// File: rtl/key_edge.sv
// N-bit press detector: one-cycle strobe when a key leaves its released level.
module key_edge
    import microwave_pkg::*;
#(
    parameter int unsigned N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] key_i,
    output logic [N-1:0] press_o
);

    logic [N-1:0] prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= {N{KEY_RELEASED}};
        end else begin
            prev_q <= key_i;
        end
    end

    assign press_o = (prev_q ~^ {N{KEY_RELEASED}}) & (key_i ^ {N{KEY_RELEASED}});

endmodule

// File: rtl/microwave_ctrl.sv
// Microwave oven sequencer: load, countdown, pause/resume, power duty cycling
// and a timed completion beep.
module microwave_ctrl
    import microwave_pkg::*;
#(
    parameter int unsigned TIME_W    = 12,
    parameter int unsigned PWR_W     = 3,
    parameter int unsigned DONE_HOLD = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              startn,
    input  logic              stopn,
    input  logic              clearn,
    input  logic              door_closed,
    input  logic              tick,
    input  logic              load_en,
    input  logic [TIME_W-1:0] load_time,
    input  logic [PWR_W-1:0]  load_power,
    output logic              mag_on,
    output logic [TIME_W-1:0] remaining,
    output logic [2:0]        state,
    output logic              done_pulse,
    output logic              beep
);

    localparam int unsigned         HOLD_W    = $clog2(DONE_HOLD + 1);
    localparam logic [TIME_W-1:0]   ONE_SEC   = TIME_W'(1);
    localparam logic [PWR_W-1:0]    ONE_PHASE = PWR_W'(1);
    localparam logic [HOLD_W-1:0]   ONE_HOLD  = HOLD_W'(1);
    localparam logic [HOLD_W-1:0]   HOLD_INIT = HOLD_W'(DONE_HOLD);

    state_e              state_q, state_d;
    logic [TIME_W-1:0]   remaining_q, remaining_d;
    logic [PWR_W-1:0]    power_q, power_d;
    logic [PWR_W-1:0]    phase_q, phase_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                done_pulse_q, done_pulse_d;
    logic                beep_q, beep_d;

    logic [2:0] press;
    logic       start_p, stop_p, clear_p;

    key_edge #(.N(3)) u_keys (
        .clk     (clk),
        .rst     (rst),
        .key_i   ({clearn, stopn, startn}),
        .press_o (press)
    );

    assign start_p = press[0];
    assign stop_p  = press[1];
    assign clear_p = press[2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            remaining_q  <= '0;
            power_q      <= '0;
            phase_q      <= '0;
            hold_q       <= '0;
            done_pulse_q <= 1'b0;
            beep_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            power_q      <= power_d;
            phase_q      <= phase_d;
            hold_q       <= hold_d;
            done_pulse_q <= done_pulse_d;
            beep_q       <= beep_d;
        end
    end

    // Each branch chain follows event priority: clear, stop, door, start, load, tick.
    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        power_d      = power_q;
        phase_d      = phase_q;
        hold_d       = hold_q;
        done_pulse_d = 1'b0;
        beep_d       = beep_q;

        case (state_q)
            ST_IDLE, ST_ARMED: begin
                if (clear_p || stop_p) begin
                    state_d     = ST_IDLE;
                    remaining_d = '0;
                end else if (state_q == ST_ARMED && start_p && door_closed) begin
                    state_d = ST_COOK;
                    phase_d = '0;
                end else if (load_en && load_time != '0) begin
                    state_d     = ST_ARMED;
                    remaining_d = load_time;
                    power_d     = load_power;
                end
            end
            ST_COOK: begin
                if (clear_p) begin
                    state_d     = ST_IDLE;
                    remaining_d = '0;
                end else if (stop_p || !door_closed) begin
                    state_d = ST_PAUSED;
                end else if (tick) begin
                    if (remaining_q > ONE_SEC) begin
                        remaining_d = remaining_q - ONE_SEC;
                        phase_d     = phase_q + ONE_PHASE;
                    end else begin
                        remaining_d  = '0;
                        state_d      = ST_DONE;
                        done_pulse_d = 1'b1;
                        beep_d       = 1'b1;
                        hold_d       = HOLD_INIT;
                    end
                end
            end
            ST_PAUSED: begin
                if (clear_p || stop_p) begin
                    state_d     = ST_IDLE;
                    remaining_d = '0;
                end else if (start_p && door_closed) begin
                    state_d = ST_COOK;
                end
            end
            ST_DONE: begin
                if (clear_p || stop_p) begin
                    state_d     = ST_IDLE;
                    remaining_d = '0;
                    beep_d      = 1'b0;
                end else if (tick) begin
                    if (hold_q <= ONE_HOLD) begin
                        hold_d  = '0;
                        beep_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        hold_d = hold_q - ONE_HOLD;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Door is used directly so opening it cuts power without waiting for a clock.
    assign mag_on     = (state_q == ST_COOK) & door_closed & (phase_q <= power_q);
    assign remaining  = remaining_q;
    assign state      = state_q;
    assign done_pulse = done_pulse_q;
    assign beep       = beep_q;

endmodule

// File: tb/tb_microwave_ctrl.sv
// Self-checking bench for microwave_ctrl: vector table, directed corner
// sequences and randomized traffic against an event-priority reference model.
module tb_microwave_ctrl;

    logic        clk, rst;
    logic        startn, stopn, clearn, door_closed, tick, load_en;
    logic [11:0] load_time;
    logic [2:0]  load_power;
    logic        mag_on, done_pulse, beep;
    logic [11:0] remaining;
    logic [2:0]  state;

    int n_chk  = 0;
    int n_pass = 0;

    microwave_ctrl #(.TIME_W(12), .PWR_W(3), .DONE_HOLD(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .startn      (startn),
        .stopn       (stopn),
        .clearn      (clearn),
        .door_closed (door_closed),
        .tick        (tick),
        .load_en     (load_en),
        .load_time   (load_time),
        .load_power  (load_power),
        .mag_on      (mag_on),
        .remaining   (remaining),
        .state       (state),
        .done_pulse  (done_pulse),
        .beep        (beep)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: ints, events resolved in priority order.
    localparam int NPH  = 8;
    localparam int HOLD = 3;
    int m_st, m_rem, m_pow, m_ph, m_hold, m_pulse, m_beep;
    bit ps, pp, pc, s_e, p_e, c_e;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_st = 0; m_rem = 0; m_pow = 0; m_ph = 0; m_hold = 0;
            m_pulse = 0; m_beep = 0; ps = 1; pp = 1; pc = 1;
        end else begin
            s_e = ps && !startn; p_e = pp && !stopn; c_e = pc && !clearn;
            ps = startn; pp = stopn; pc = clearn;
            m_pulse = 0;
            if (c_e || (p_e && m_st != 2)) begin
                m_st = 0; m_rem = 0; m_beep = 0;
            end else if (p_e || (!door_closed && m_st == 2)) begin
                m_st = 3;
            end else if (s_e && door_closed && (m_st == 1 || m_st == 3)) begin
                if (m_st == 1) m_ph = 0;
                m_st = 2;
            end else if (load_en && load_time != 0 && m_st <= 1) begin
                m_rem = int'(load_time); m_pow = int'(load_power); m_st = 1;
            end else if (tick && m_st == 2) begin
                if (m_rem > 1) begin
                    m_rem = m_rem - 1; m_ph = (m_ph + 1) % NPH;
                end else begin
                    m_rem = 0; m_st = 4; m_pulse = 1; m_beep = 1; m_hold = HOLD;
                end
            end else if (tick && m_st == 4) begin
                m_hold = m_hold - 1;
                if (m_hold == 0) begin m_st = 0; m_beep = 0; end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic drv(input int s, input int p, input int c, input int d,
                       input int t, input int le, input int lt, input int lp);
        @(negedge clk);
        startn = s[0]; stopn = p[0]; clearn = c[0]; door_closed = d[0];
        tick = t[0]; load_en = le[0]; load_time = lt[11:0]; load_power = lp[2:0];
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int s, p, c, d, t, le, lt, lp;
        int st, rem, mag, pul, bp;
    } vec_t;

    function automatic vec_t mk(int s, int p, int c, int d, int t, int le, int lt,
                                int lp, int st, int rem, int mag, int pul, int bp);
        vec_t v;
        v.s = s; v.p = p; v.c = c; v.d = d; v.t = t; v.le = le; v.lt = lt; v.lp = lp;
        v.st = st; v.rem = rem; v.mag = mag; v.pul = pul; v.bp = bp;
        return v;
    endfunction

    vec_t tbl[9];
    int   cnt, bad;

    initial begin
        startn = 1; stopn = 1; clearn = 1; door_closed = 1; tick = 0;
        load_en = 0; load_time = 0; load_power = 0;

        // Full 3 s cook at full power followed by the beep hold.
        tbl[0] = mk(1,1,1,1,0,1,3,7, 1,3,0,0,0);
        tbl[1] = mk(0,1,1,1,0,0,0,0, 2,3,1,0,0);
        tbl[2] = mk(1,1,1,1,1,0,0,0, 2,2,1,0,0);
        tbl[3] = mk(1,1,1,1,1,0,0,0, 2,1,1,0,0);
        tbl[4] = mk(1,1,1,1,1,0,0,0, 4,0,0,1,1);
        tbl[5] = mk(1,1,1,1,0,0,0,0, 4,0,0,0,1);
        tbl[6] = mk(1,1,1,1,1,0,0,0, 4,0,0,0,1);
        tbl[7] = mk(1,1,1,1,1,0,0,0, 4,0,0,0,1);
        tbl[8] = mk(1,1,1,1,1,0,0,0, 0,0,0,0,0);

        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", int'(state), 0);
        chk("reset_remaining", int'(remaining), 0);
        chk("reset_mag_on", int'(mag_on), 0);
        chk("reset_done_pulse", int'(done_pulse), 0);
        chk("reset_beep", int'(beep), 0);
        @(negedge clk);
        rst = 0;

        for (int i = 0; i < 9; i++) begin
            drv(tbl[i].s, tbl[i].p, tbl[i].c, tbl[i].d, tbl[i].t, tbl[i].le, tbl[i].lt, tbl[i].lp);
            chk($sformatf("tbl%0d_state", i), int'(state), tbl[i].st);
            chk($sformatf("tbl%0d_remaining", i), int'(remaining), tbl[i].rem);
            chk($sformatf("tbl%0d_mag_on", i), int'(mag_on), tbl[i].mag);
            chk($sformatf("tbl%0d_done_pulse", i), int'(done_pulse), tbl[i].pul);
            chk($sformatf("tbl%0d_beep", i), int'(beep), tbl[i].bp);
        end

        // Power 1: magnetron on in phases 0-1 of each 8-tick window.
        drv(1,1,1,1,0,1,16,1);
        drv(0,1,1,1,0,0,0,0);
        chk("pwr1_cook", int'(state), 2);
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            cnt += int'(mag_on);
            drv(1,1,1,1,1,0,0,0);
        end
        chk("pwr1_on_ticks", cnt, 4);
        chk("pwr1_done", int'(state), 4);
        repeat (3) drv(1,1,1,1,1,0,0,0);
        chk("pwr1_back_idle", int'(state), 0);

        // Door opened mid-cook.
        drv(1,1,1,1,0,1,8,7);
        drv(0,1,1,1,0,0,0,0);
        repeat (3) drv(1,1,1,1,1,0,0,0);
        chk("door_rem_before", int'(remaining), 5);
        @(negedge clk);
        door_closed = 0;
        #1;
        chk("door_mag_immediate", int'(mag_on), 0);
        chk("door_state_held_until_edge", int'(state), 2);
        @(posedge clk);
        #1;
        chk("door_paused", int'(state), 3);
        repeat (2) drv(1,1,1,0,1,0,0,0);
        chk("door_rem_frozen", int'(remaining), 5);
        drv(1,1,1,1,0,0,0,0);
        chk("door_closed_no_start", int'(state), 3);
        drv(0,1,1,1,0,0,0,0);
        chk("door_resume_state", int'(state), 2);
        chk("door_resume_rem", int'(remaining), 5);
        drv(1,1,1,1,1,0,0,0);
        chk("door_resume_dec", int'(remaining), 4);
        drv(1,1,0,1,0,0,0,0);
        chk("clear_cook_state", int'(state), 0);
        chk("clear_cook_rem", int'(remaining), 0);
        drv(1,1,1,1,0,0,0,0);

        // Stop coinciding with tick.
        drv(1,1,1,1,0,1,6,7);
        drv(0,1,1,1,0,0,0,0);
        drv(1,1,1,1,1,0,0,0);
        chk("stop_rem_before", int'(remaining), 5);
        drv(1,0,1,1,1,0,0,0);
        chk("stop_tick_state", int'(state), 3);
        chk("stop_tick_rem", int'(remaining), 5);
        drv(1,1,1,1,0,0,0,0);
        drv(1,0,1,1,0,0,0,0);
        chk("stop2_state", int'(state), 0);
        chk("stop2_rem", int'(remaining), 0);
        drv(1,1,1,1,0,0,0,0);

        // Start held with door open, then a clean press with door closed.
        drv(1,1,1,1,0,1,4,2);
        chk("armed_state", int'(state), 1);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            drv(0,1,1,0,0,0,0,0);
            if (state != 3'd1) bad++;
        end
        chk("held_start_cycles_off_armed", bad, 0);
        drv(1,1,1,1,0,0,0,0);
        chk("release_still_armed", int'(state), 1);
        drv(0,1,1,1,0,0,0,0);
        chk("repress_cook", int'(state), 2);
        drv(1,1,0,1,0,0,0,0);
        drv(1,1,1,1,0,1,0,5);
        chk("zero_load_state", int'(state), 0);
        chk("zero_load_rem", int'(remaining), 0);

        // Asynchronous reset mid-cook.
        drv(1,1,1,1,0,1,9,7);
        drv(0,1,1,1,0,0,0,0);
        drv(1,1,1,1,1,0,0,0);
        drv(1,1,1,1,1,0,0,0);
        chk("pre_rst_rem", int'(remaining), 7);
        @(negedge clk);
        #2;
        rst = 1;
        #1;
        chk("async_rst_mag", int'(mag_on), 0);
        chk("async_rst_state", int'(state), 0);
        chk("async_rst_rem", int'(remaining), 0);
        #1;
        rst = 0;
        drv(0,1,1,1,0,0,0,0);
        chk("post_rst_start_ignored", int'(state), 0);
        drv(1,1,1,1,0,0,0,0);
        chk("post_rst_rem", int'(remaining), 0);

        // Randomized traffic against the reference model.
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < 3000; i++) begin
            drv(int'($urandom_range(0, 7) != 0), int'($urandom_range(0, 15) != 0),
                int'($urandom_range(0, 31) != 0), int'($urandom_range(0, 15) != 0),
                int'($urandom_range(0, 3) == 0), int'($urandom_range(0, 7) == 0),
                int'($urandom_range(0, 12)), int'($urandom_range(0, 7)));
            chk("rand_state", int'(state), m_st);
            chk("rand_remaining", int'(remaining), m_rem);
            chk("rand_mag_on", int'(mag_on), int'(m_st == 2 && door_closed && m_ph <= m_pow));
            chk("rand_done_pulse", int'(done_pulse), m_pulse);
            chk("rand_beep", int'(beep), m_beep);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/microwave_ctrl.md
Name: microwave_ctrl

Overview:
Sequential successor to the combinational AND/OR/NOT magnetron enable. Owns the cook countdown, pause/resume and power-level duty cycling. A done annunciator is generated internally, so no external timer_done is needed. Sits between the debounced/synchronised keypad inputs, the door switch, the 1 Hz tick generator and the magnetron driver.

Parameters:
TIME_W, 12, width of cook time in seconds (max 2^TIME_W-1).
PWR_W, 3, width of power level; levels 0..2^PWR_W-1.
DONE_HOLD, 3, ticks the beep output stays high after completion (>=1).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
startn  in  1  start key, active-low level, already synchronised to clk
stopn  in  1  stop key, active-low level, synchronised
clearn  in  1  clear key, active-low level, synchronised
door_closed  in  1  1 = door closed
tick  in  1  one-clk-wide 1 Hz strobe
load_en  in  1  load cook time/power this cycle
load_time  in  TIME_W  cook time in seconds
load_power  in  PWR_W  power level
mag_on  out  1  magnetron enable
remaining  out  TIME_W  seconds left
state  out  3  current FSM state code
done_pulse  out  1  one-clk pulse on entry to DONE
beep  out  1  high while annunciating completion

Behaviour:
- Reset (async, rst=1): state=IDLE, remaining=0, power_q=0, phase=0, beep=0, done_pulse=0, mag_on=0. Key-history registers reset to 1 (released).
- Key press = registered falling edge (prev=1, now=0). Holding a key produces exactly one press.
- State codes: IDLE=0, ARMED=1, COOK=2, PAUSED=3, DONE=4. Codes 5-7 are illegal and go to IDLE next clk.
- Event priority within a cycle: clear > stop > door open > start > load > tick.
- IDLE/ARMED: load_en with load_time!=0 -> remaining=load_time, power_q=load_power, state=ARMED. load_time==0 is ignored. Load is ignored in COOK/PAUSED/DONE.
- ARMED: start press with door_closed=1 -> COOK, phase=0. Start with door open is ignored. Clear or stop press -> IDLE, remaining=0.
- COOK, evaluated on tick:
  - If remaining>1: remaining-1, phase+1 (wraps at 2^PWR_W).
  - If remaining==1: remaining=0, state=DONE, done_pulse=1 for one clk, beep=1, hold counter=DONE_HOLD.
- COOK interruptions:
  - door_closed=0 -> PAUSED; remaining and phase are frozen.
  - stop press -> PAUSED.
  - clear press -> IDLE, remaining=0.
  - A simultaneous tick is discarded (no decrement).
- PAUSED: start press with door_closed=1 -> COOK, resuming the held remaining and phase. Stop or clear press -> IDLE, remaining=0.
- DONE: each tick decrements the hold counter; at 0, beep=0 and state=IDLE. Clear/stop press -> beep=0, IDLE immediately. Start is ignored.
- mag_on = (state==COOK) & door_closed & (phase <= power_q). It is combinational on door_closed so that door opening kills the magnetron in the same cycle.
  - power_q = 2^PWR_W-1 gives continuous on.
  - power_q = 0 gives 1 tick of every 2^PWR_W.
- remaining never underflows and never wraps. All outputs change only on clk edges, except mag_on via door_closed.
- rst asserted mid-cook: immediate IDLE with mag_on=0.

Decomposition:
- Package microwave_pkg holds the state enum/localparams (IDLE..DONE) and the key-edge polarity constant.
- One sub-module, key_edge: parametrised N-bit falling-edge detector with async reset to all-ones. Instantiated once with N=3 for start/stop/clear.
- The FSM, countdown, duty phase and done-hold counter remain in microwave_ctrl.

Test Plan:
1. Load 3 s at power 7, door closed, press start, 3 ticks:
   - mag_on stays 1 throughout.
   - remaining goes 3->2->1->0.
   - done_pulse fires once, beep is high for 3 ticks, then state=0.
2. Power 1 (PWR_W=3), 16 s cook:
   - mag_on is high during phases 0-1 of each 8-tick window, i.e. 4 of 16 ticks.
3. Cooking at remaining=5, open the door:
   - mag_on=0 in the same cycle; state=3; remaining stays 5 across ticks.
   - Close the door and press start: COOK resumes 5->4.
4. In COOK, assert stop press and tick in the same cycle:
   - state=3, remaining is not decremented.
   - A second stop press gives state=0, remaining=0.
5. Hold startn low for 20 clks in ARMED with the door open:
   - No transition; releasing and re-pressing with the door closed enters COOK.
   - load_time=0 in IDLE stays IDLE.
6. Assert rst mid-COOK, asynchronously between clk edges:
   - mag_on, state and remaining all go to 0 immediately.
   - After release, the block ignores a start until a new load.
